// File: rtl/parity_engine.sv
// -----------------------------------------------------------------------------
// parity_engine
//
// Serial parity engine. A start pulse in IDLE captures a DATA_W-bit word, the
// received parity bit and the even/odd convention. The word is then scanned
// one bit per clock while the ones are counted. When the scan completes, the
// ones count, even/odd parity and the parity-error flag are loaded, and done
// pulses for one cycle. Results then hold until the next accepted start.
//
// Optional feature macro: PARITY_ENGINE_EARLY_EXIT_EN
//   When defined, the scan ends as soon as no set bits remain above the bit
//   being processed. Latency is the index of the highest set bit + 1, with a
//   minimum of 1. The results are identical to a full scan.
//   When undefined, the latency is always DATA_W cycles.
//
// Parameters:
//   DATA_W      word width, 2..64
//   CNT_W       ones-counter width, derived from DATA_W (do not override)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request; sampled only in IDLE
//   data_in     word to check, captured on the accepted start edge
//   parity_in   received parity bit, captured with data_in
//   odd_mode    0 = even convention, 1 = odd convention, captured with data_in
//   busy        high from the accepted start until the return to IDLE
//   done        one-cycle strobe; results valid
//   ones_count  number of ones in the captured word
//   even_parity ones count is even
//   odd_parity  ones count is odd
//   parity_err  ^word ^ parity_in ^ odd_mode
// -----------------------------------------------------------------------------
module parity_engine #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              odd_mode,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  ones_count,
    output logic              even_parity,
    output logic              odd_parity,
    output logic              parity_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DATA_W-1:0]  sreg;
    logic [CNT_W-1:0]   acc;
    logic [CNT_W-1:0]   bit_cnt;
    logic               par_cap;
    logic               odd_cap;

    logic [CNT_W-1:0]   acc_nxt;
    logic               scan_last;

    // The running count includes the bit being shifted out on this edge.
    // The final results are therefore loaded from acc_nxt, not from acc.
    always_comb begin
        acc_nxt = acc + {{(CNT_W-1){1'b0}}, sreg[0]};
    end

`ifdef PARITY_ENGINE_EARLY_EXIT_EN
    // Stop once nothing above bit 0 remains set. Any bits left after this
    // are zero and cannot change the count.
    always_comb begin
        scan_last = (bit_cnt == CNT_W'(DATA_W - 1)) || (sreg[DATA_W-1:1] == '0);
    end
`else
    always_comb begin
        scan_last = (bit_cnt == CNT_W'(DATA_W - 1));
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg        <= '0;
            acc         <= '0;
            bit_cnt     <= '0;
            par_cap     <= 1'b0;
            odd_cap     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ones_count  <= '0;
            even_parity <= 1'b0;
            odd_parity  <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg        <= data_in;
                        par_cap     <= parity_in;
                        odd_cap     <= odd_mode;
                        acc         <= '0;
                        bit_cnt     <= '0;
                        busy        <= 1'b1;
                        ones_count  <= '0;
                        even_parity <= 1'b0;
                        odd_parity  <= 1'b0;
                        parity_err  <= 1'b0;
                    end
                end
                SCAN: begin
                    acc     <= acc_nxt;
                    sreg    <= sreg >> 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (scan_last) begin
                        done        <= 1'b1;
                        ones_count  <= acc_nxt;
                        even_parity <= ~acc_nxt[0];
                        odd_parity  <= acc_nxt[0];
                        parity_err  <= acc_nxt[0] ^ par_cap ^ odd_cap;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
